// File: rtl/addr_latch_decoder.sv
// Clocked addressable latch bank plus registered active-low one-hot decoder.
// Optional strobe sequencer (busy, timed dec_n strobe) enabled by macro ALD_PULSE_EN.
module addr_latch_decoder #(
  parameter  int SEL_W     = 3,
  parameter  int PULSE_LEN = 4,
  localparam int N_OUT     = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             g_n,
  input  logic             clr_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             d,
  input  logic             pulse,
  output logic [N_OUT-1:0] q,
  output logic [N_OUT-1:0] dec_n,
  output logic             busy
);

  localparam logic [N_OUT-1:0] LP_ONE = N_OUT'(1);

  logic [N_OUT-1:0] r_q;
  logic [N_OUT-1:0] r_dec_n;
  logic [N_OUT-1:0] w_q_next;
  logic [N_OUT-1:0] w_dec_next;

  // Latch-bank mode is {g_n, clr_n}: 01 addressable, 11 memory, 00 demux, 10 clear.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_q_next = r_q;
    unique case ({g_n, clr_n})
      2'b01: w_q_next[sel] = d;
      2'b00: begin
        w_q_next      = '0;
        w_q_next[sel] = d;
      end
      2'b10:   w_q_next = '0;
      default: w_q_next = r_q;
    endcase
  end

  always_comb begin
    w_dec_next = '1;
    if (!g_n) w_dec_next = ~(LP_ONE << sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      r_dec_n <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      r_q     <= w_q_next;
      r_dec_n <= w_dec_next;
    end
  end

  assign q = r_q;

`ifdef ALD_PULSE_EN
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam logic [7:0] LP_CNT_LOAD = 8'(PULSE_LEN - 1);

  logic [0:0]       r_state;
  logic [7:0]       r_cnt;
  logic [SEL_W-1:0] r_psel;
  logic             r_busy;
  logic [N_OUT-1:0] w_strobe_mask;

  // A new request while ACTIVE restarts the strobe on the new address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_psel  <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (pulse) begin
            r_state <= ACTIVE;
            r_psel  <= sel;
            r_cnt   <= LP_CNT_LOAD;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          if (pulse) begin
            r_psel <= sel;
            r_cnt  <= LP_CNT_LOAD;
          end else if (r_cnt == 8'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
      endcase
    end
  end

  // Strobe and normal decode are both registered, so the AND cannot glitch between edges.
  assign w_strobe_mask = (r_state == ACTIVE) ? (LP_ONE << r_psel) : '0;
  assign dec_n         = r_dec_n & ~w_strobe_mask;
  assign busy          = r_busy;
`else
  logic w_unused_pulse;

  assign w_unused_pulse = ^{pulse, 8'(PULSE_LEN)};
  assign dec_n          = r_dec_n;
  assign busy           = 1'b0;
`endif

endmodule

// File: tb/tb_addr_latch_decoder.sv
// Directed self-checking bench for addr_latch_decoder (SEL_W=3, PULSE_LEN=4).
// Expected strobe values follow ALD_PULSE_EN when the bench is built with that macro.
module tb_addr_latch_decoder;

  logic       clk;
  logic       reset;
  logic       g_n;
  logic       clr_n;
  logic [2:0] sel;
  logic       d;
  logic       pulse;
  logic [7:0] q;
  logic [7:0] dec_n;
  logic       busy;

  int n_compared;
  int n_mismatched;

  addr_latch_decoder #(.SEL_W(3), .PULSE_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .g_n   (g_n),
    .clr_n (clr_n),
    .sel   (sel),
    .d     (d),
    .pulse (pulse),
    .q     (q),
    .dec_n (dec_n),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALD_PULSE_EN
  localparam bit PULSE_ON = 1'b1;
`else
  localparam bit PULSE_ON = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; g_n = 1'b1; clr_n = 1'b1; sel = 3'd0; d = 1'b0; pulse = 1'b0;
    #12;
    n_compared++;
    if (q !== 8'h00) begin n_mismatched++; $display("FAIL reset_q got=%h exp=00", q); end
    n_compared++;
    if (dec_n !== 8'hFF) begin n_mismatched++; $display("FAIL reset_dec got=%h exp=FF", dec_n); end
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latch();
    logic [7:0] exp_q   [2] = '{8'h04, 8'h24};
    logic [7:0] exp_dec [2] = '{8'hFB, 8'hDF};
    logic [2:0] sels    [2] = '{3'd2, 3'd5};
    g_n = 1'b0; clr_n = 1'b1; d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sel = sels[i];
      tick();
      n_compared++;
      if (q !== exp_q[i]) begin n_mismatched++; $display("FAIL latch_q[%0d] got=%h exp=%h", i, q, exp_q[i]); end
      n_compared++;
      if (dec_n !== exp_dec[i]) begin n_mismatched++; $display("FAIL latch_dec[%0d] got=%h exp=%h", i, dec_n, exp_dec[i]); end
    end
    g_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = 3'(i * 3 + 1);
      d   = i[0];
      tick();
      n_compared++;
      if (q !== 8'h24) begin n_mismatched++; $display("FAIL memory_q[%0d] got=%h exp=24", i, q); end
      n_compared++;
      if (dec_n !== 8'hFF) begin n_mismatched++; $display("FAIL memory_dec[%0d] got=%h exp=FF", i, dec_n); end
    end
  endtask

  task automatic test_demux_clear();
    g_n = 1'b0; clr_n = 1'b0; sel = 3'd6; d = 1'b1;
    tick();
    n_compared++;
    if (q !== 8'h40) begin n_mismatched++; $display("FAIL demux_q got=%h exp=40", q); end
    n_compared++;
    if (dec_n !== 8'hBF) begin n_mismatched++; $display("FAIL demux_dec got=%h exp=BF", dec_n); end
    g_n = 1'b1; clr_n = 1'b0; sel = 3'd1;
    tick();
    n_compared++;
    if (q !== 8'h00) begin n_mismatched++; $display("FAIL clear_q got=%h exp=00", q); end
    n_compared++;
    if (dec_n !== 8'hFF) begin n_mismatched++; $display("FAIL clear_dec got=%h exp=FF", dec_n); end
  endtask

  task automatic test_decode();
    logic [7:0] exp_dec [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    g_n = 1'b0; clr_n = 1'b1; d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick();
      n_compared++;
      if (dec_n !== exp_dec[i]) begin n_mismatched++; $display("FAIL decode[%0d] got=%h exp=%h", i, dec_n, exp_dec[i]); end
    end
    n_compared++;
    if (q !== 8'h00) begin n_mismatched++; $display("FAIL decode_q got=%h exp=00", q); end
    g_n = 1'b1;
    tick();
    n_compared++;
    if (dec_n !== 8'hFF) begin n_mismatched++; $display("FAIL decode_off got=%h exp=FF", dec_n); end
  endtask

  task automatic test_pulse();
    logic [7:0] e_dec;
    logic       e_busy;
    g_n = 1'b1; clr_n = 1'b1; d = 1'b0;
    sel = 3'd3; pulse = 1'b1;
    tick();
    pulse = 1'b0; sel = 3'd0;
    for (int k = 0; k < 5; k++) begin
      e_dec  = (PULSE_ON && k < 4) ? 8'hF7 : 8'hFF;
      e_busy = PULSE_ON && k < 4;
      n_compared++;
      if (dec_n !== e_dec) begin n_mismatched++; $display("FAIL pulse_dec[%0d] got=%h exp=%h", k, dec_n, e_dec); end
      n_compared++;
      if (busy !== e_busy) begin n_mismatched++; $display("FAIL pulse_busy[%0d] got=%b exp=%b", k, busy, e_busy); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e_dec;
    logic       e_busy;
    g_n = 1'b1; clr_n = 1'b1; d = 1'b0;
    sel = 3'd3; pulse = 1'b1;
    tick();
    pulse = 1'b0;
    tick();
    e_dec = PULSE_ON ? 8'hF7 : 8'hFF;
    n_compared++;
    if (dec_n !== e_dec) begin n_mismatched++; $display("FAIL retrig_pre got=%h exp=%h", dec_n, e_dec); end
    sel = 3'd1; pulse = 1'b1;
    tick();
    pulse = 1'b0; sel = 3'd0;
    for (int k = 0; k < 5; k++) begin
      e_dec  = (PULSE_ON && k < 4) ? 8'hFD : 8'hFF;
      e_busy = PULSE_ON && k < 4;
      n_compared++;
      if (dec_n !== e_dec) begin n_mismatched++; $display("FAIL retrig_dec[%0d] got=%h exp=%h", k, dec_n, e_dec); end
      n_compared++;
      if (busy !== e_busy) begin n_mismatched++; $display("FAIL retrig_busy[%0d] got=%b exp=%b", k, busy, e_busy); end
      tick();
    end
  endtask

  task automatic test_overlap();
    logic [7:0] e_dec;
    g_n = 1'b1; clr_n = 1'b1; d = 1'b0;
    sel = 3'd3; pulse = 1'b1;
    tick();
    pulse = 1'b0; g_n = 1'b0; sel = 3'd5;
    tick();
    e_dec = PULSE_ON ? 8'hD7 : 8'hDF;
    n_compared++;
    if (dec_n !== e_dec) begin n_mismatched++; $display("FAIL overlap_dec got=%h exp=%h", dec_n, e_dec); end
    g_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_compared++;
    if (dec_n !== 8'hFF) begin n_mismatched++; $display("FAIL overlap_end got=%h exp=FF", dec_n); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e_dec;
    g_n = 1'b0; clr_n = 1'b1; sel = 3'd7; d = 1'b1; pulse = 1'b1;
    tick();
    pulse = 1'b0;
    e_dec = 8'h7F;
    n_compared++;
    if (q !== 8'h80) begin n_mismatched++; $display("FAIL midrst_pre_q got=%h exp=80", q); end
    n_compared++;
    if (dec_n !== e_dec) begin n_mismatched++; $display("FAIL midrst_pre_dec got=%h exp=%h", dec_n, e_dec); end
    #2 reset = 1'b1;
    #1;
    n_compared++;
    if (q !== 8'h00) begin n_mismatched++; $display("FAIL midrst_q got=%h exp=00", q); end
    n_compared++;
    if (dec_n !== 8'hFF) begin n_mismatched++; $display("FAIL midrst_dec got=%h exp=FF", dec_n); end
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    #1 reset = 1'b0;
    g_n = 1'b1; d = 1'b0;
    tick();
    n_compared++;
    if (dec_n !== 8'hFF) begin n_mismatched++; $display("FAIL midrst_after got=%h exp=FF", dec_n); end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_latch();
    test_demux_clear();
    test_decode();
    test_pulse();
    test_back_to_back();
    test_overlap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
